// File: rtl/mfp_ahb_lite_master_pkg.sv
// mfp_ahb_lite_master_pkg: AHB-Lite encodings and command legality helper
package mfp_ahb_lite_master_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;
  function automatic logic cmd_legal(input logic [31:0] addr, input logic [2:0] size);
    return (size == HSIZE_BYTE) || (size == HSIZE_HALF && !addr[0]) ||
           (size == HSIZE_WORD && addr[1:0] == 2'b00);
  endfunction
endpackage

// File: rtl/mfp_ahb_lite_master.sv
// mfp_ahb_lite_master: valid/ready command stream to pipelined AHB-Lite NONSEQ/SINGLE transfers
module mfp_ahb_lite_master
  import mfp_ahb_lite_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VALUE = HPROT_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);
  logic        a_valid, a_write, d_valid, d_write, cancel, a_adv, accept;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_size;
  always_comb begin
    HTRANS    = (a_valid && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    a_adv     = (HTRANS == HTRANS_NONSEQ) && HREADY;
    cmd_ready = !a_valid || a_adv;
    accept    = cmd_valid && cmd_ready;
  end
  assign HADDR     = a_addr;
  assign HWRITE    = a_write;
  assign HSIZE     = a_size;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VALUE;
  assign HMASTLOCK = 1'b0;
  // address slot keeps its fields after advancing so HADDR stays stable while idle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_wdata <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_addr  <= cmd_addr;
      a_write <= cmd_write;
      a_size  <= cmd_size;
      a_wdata <= cmd_wdata;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else if (a_adv) begin
      d_valid <= 1'b1;
      d_write <= a_write;
      HWDATA  <= a_wdata;
    end else if (d_valid && HREADY) begin
      d_valid <= 1'b0;
    end
  end
  // first ERROR cycle idles the bus for the second; the slot command is reissued afterwards
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) cancel <= 1'b0;
    else if (d_valid && HREADY) cancel <= 1'b0;
    else if (d_valid && HRESP && !HREADY) cancel <= 1'b1;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= d_valid && HREADY;
      if (d_valid && HREADY) begin
        rsp_error <= HRESP;
        if (!d_write) rsp_rdata <= HRDATA;
      end
    end
  end
endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// tb_mfp_ahb_lite_master: scoreboard bench with a behavioural AHB slave and memory model
module tb_mfp_ahb_lite_master;
  import mfp_ahb_lite_master_pkg::*;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = '0;
  logic        cmd_ready, rsp_valid, rsp_error, HWRITE, HMASTLOCK;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic        HREADY, HRESP;
  logic [31:0] HRDATA;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  typedef struct {logic [31:0] addr; logic write; logic [2:0] size; int waits; logic err;} plan_t;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  plan_t plan_q[$];
  exp_t  exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] last_rd = '0;
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // behavioural slave: each data phase follows the plan chosen when its command was accepted
  logic        s_act = 1'b0, s_err = 1'b0, s_err1 = 1'b0, s_write = 1'b0;
  logic [31:0] s_addr = '0, n_addr, n_wdata;
  logic [1:0]  n_trans;
  logic        n_write;
  logic [2:0]  n_size;
  int          s_wait = 0;
  initial begin
    plan_t p;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(negedge HCLK);
      n_trans = HTRANS; n_addr = HADDR; n_write = HWRITE; n_size = HSIZE; n_wdata = HWDATA;
      @(posedge HCLK);
      #1;
      if (!HRESETn) s_act = 1'b0;
      else begin
        if (s_act && HREADY) begin
          if (s_write && !s_err) slv_mem[s_addr] = n_wdata;
          s_act = 1'b0;
        end else if (s_act) begin
          if (s_wait > 0) s_wait--;
          else if (s_err) s_err1 = 1'b1;
        end
        if (n_trans == HTRANS_NONSEQ && HREADY) begin
          if (plan_q.size() == 0) fail("unexpected_address_phase");
          else begin
            p = plan_q.pop_front();
            chk("haddr", n_addr, p.addr);
            chk("hwrite", {31'b0, n_write}, {31'b0, p.write});
            chk("hsize", {29'b0, n_size}, {29'b0, p.size});
            s_act = 1'b1; s_wait = p.waits; s_err = p.err; s_err1 = 1'b0;
            s_addr = n_addr; s_write = n_write;
          end
        end
      end
      HRDATA = $urandom;
      if (!s_act) begin HREADY = 1'b1; HRESP = 1'b0; end
      else if (s_wait > 0) begin HREADY = 1'b0; HRESP = 1'b0; end
      else if (s_err && !s_err1) begin HREADY = 1'b0; HRESP = 1'b1; end
      else begin
        HREADY = 1'b1; HRESP = s_err;
        if (!s_write) HRDATA = slv_mem.exists(s_addr) ? slv_mem[s_addr] : s_addr + 32'd1;
      end
    end
  end

  // monitor: scoreboard pops on rsp_valid, plus per-cycle protocol checks
  logic        pv = 1'b0, p_ready, p_resp;
  logic [1:0]  p_trans;
  logic [31:0] p_addr, p_wdata;
  int nonseq_run = 0, nonseq_max = 0, rsp_run = 0, rsp_max = 0, rsp_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        chk("rsp_valid_in_reset", {31'b0, rsp_valid}, 0);
        pv = 1'b0;
        continue;
      end
      chk("htrans_legal", {31'b0, (HTRANS == HTRANS_IDLE || HTRANS == HTRANS_NONSEQ)}, 1);
      if (HTRANS == HTRANS_NONSEQ && !HREADY) chk("cmd_ready_wait", {31'b0, cmd_ready}, 0);
      if (HRESP && HREADY) chk("htrans_err2_idle", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
      if (pv && !p_ready) begin
        chk("hwdata_hold", HWDATA, p_wdata);
        if (p_resp) chk("htrans_cancel", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
        else if (p_trans == HTRANS_NONSEQ) begin
          chk("htrans_hold", {30'b0, HTRANS}, {30'b0, HTRANS_NONSEQ});
          chk("haddr_hold", HADDR, p_addr);
        end
      end
      nonseq_run = (HTRANS == HTRANS_NONSEQ) ? nonseq_run + 1 : 0;
      if (nonseq_run > nonseq_max) nonseq_max = nonseq_run;
      rsp_run = rsp_valid ? rsp_run + 1 : 0;
      if (rsp_run > rsp_max) rsp_max = rsp_run;
      if (rsp_valid) begin
        rsp_cnt++;
        if (exp_q.size() == 0) fail("unexpected_rsp_valid");
        else begin
          e = exp_q.pop_front();
          chk("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      pv = 1'b1; p_ready = HREADY; p_resp = HRESP; p_trans = HTRANS; p_addr = HADDR; p_wdata = HWDATA;
    end
  end

  // reference model: memory of completed-OKAY writes; unwritten reads return addr+1
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d, input int waits, input logic err);
    int n = 0;
    exp_t e;
    assert (cmd_legal(a, s)) else $error("illegal command addr=%h size=%0d", a, s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    do begin @(negedge HCLK); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) fail("cmd_accept_timeout");
    else begin
      if (w) begin
        if (!err) ref_mem[a] = d;
        e.rdata = last_rd;
      end else begin
        e.rdata = ref_mem.exists(a) ? ref_mem[a] : a + 32'd1;
        last_rd = e.rdata;
      end
      e.err = err;
      exp_q.push_back(e);
      plan_q.push_back('{addr: a, write: w, size: s, waits: waits, err: err});
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n;
    logic w, err;
    logic [2:0] s;
    logic [31:0] a;
    cycles(2);
    chk("rst_htrans", {30'b0, HTRANS}, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", {31'b0, HWRITE}, 0);
    chk("rst_hsize", {29'b0, HSIZE}, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", {31'b0, rsp_error}, 0);
    chk("hburst", {29'b0, HBURST}, 0);
    chk("hprot", {28'b0, HPROT}, 32'h3);
    chk("hmastlock", {31'b0, HMASTLOCK}, 0);
    @(negedge HCLK) HRESETn = 1'b1;
    cycles(2);
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 1);
    // single zero-wait write and its exact latency
    send(1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0, 1'b0);
    idle();
    @(negedge HCLK);
    chk("t1_htrans", {30'b0, HTRANS}, {30'b0, HTRANS_NONSEQ});
    chk("t1_hwrite", {31'b0, HWRITE}, 1);
    @(negedge HCLK);
    chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
    chk("t1_rsp_early", {31'b0, rsp_valid}, 0);
    @(negedge HCLK);
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 1);
    cycles(2);
    // four back-to-back reads
    nonseq_max = 0; rsp_max = 0;
    for (int i = 0; i < 4; i++) send(1'b0, 32'(i * 4), HSIZE_WORD, 32'h0, 0, 1'b0);
    idle();
    cycles(6);
    chk("t2_nonseq_run", nonseq_max, 4);
    chk("t2_rsp_run", rsp_max, 4);
    // byte write with two wait states
    c0 = rsp_cnt;
    send(1'b1, 32'h13, HSIZE_BYTE, 32'hAB00_0000, 2, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("t3_haddr", HADDR, 32'h13);
      chk("t3_hsize", {29'b0, HSIZE}, 0);
      if (i > 0) chk("t3_hwdata", HWDATA, 32'hAB00_0000);
    end
    cycles(4);
    chk("t3_rsp_count", rsp_cnt - c0, 1);
    send(1'b1, 32'h20, HSIZE_WORD, 32'h0BAD_F00D, 2, 1'b0);
    send(1'b0, 32'h13, HSIZE_BYTE, 32'h0, 0, 1'b0);
    idle();
    cycles(8);
    // write error followed by a read that must be reissued
    c0 = rsp_cnt;
    send(1'b1, 32'h100, HSIZE_WORD, 32'h1234_5678, 0, 1'b1);
    send(1'b0, 32'h104, HSIZE_WORD, 32'h0, 0, 1'b0);
    idle();
    cycles(8);
    chk("t4_rsp_count", rsp_cnt - c0, 2);
    send(1'b0, 32'h100, HSIZE_WORD, 32'h0, 0, 1'b0);
    idle();
    cycles(5);
    // asynchronous reset while a read waits and another is in the address phase
    send(1'b0, 32'h200, HSIZE_WORD, 32'h0, 6, 1'b0);
    send(1'b0, 32'h204, HSIZE_WORD, 32'h0, 0, 1'b0);
    idle();
    @(negedge HCLK);
    chk("t5_nonseq_before", {30'b0, HTRANS}, {30'b0, HTRANS_NONSEQ});
    @(posedge HCLK);
    #3 HRESETn = 1'b0;
    #1;
    chk("t5_htrans_async", {30'b0, HTRANS}, {30'b0, HTRANS_IDLE});
    chk("t5_haddr_async", HADDR, 0);
    exp_q.delete(); plan_q.delete(); last_rd = '0;
    cycles(3);
    @(negedge HCLK) HRESETn = 1'b1;
    cycles(1);
    c0 = rsp_cnt;
    send(1'b0, 32'h208, HSIZE_WORD, 32'h0, 1, 1'b0);
    idle();
    cycles(6);
    chk("t5_rsp_after_reset", rsp_cnt - c0, 1);
    // random stream
    for (int i = 0; i < 1000; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 2));
      a = 32'h1000 + (32'($urandom_range(0, 63)) & ~((32'd1 << s) - 32'd1));
      err = ($urandom_range(0, 7) == 0);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
      send(w, a, s, $urandom, n, err);
      if ($urandom_range(0, 2) == 0) begin
        idle();
        cycles($urandom_range(0, 2));
      end
    end
    idle();
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin cycles(1); n++; end
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_plan", plan_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
